inst_mem_responder: RTL and testbench
=====================================

# inst_mem_responder

Instruction-memory responder: the memory-side end of the fetch request interface. It accepts one word-read request at a time from the fetch stage, returns the instruction word with a one-cycle ready pulse after a fixed latency, and exposes a load port through which the boot loader writes program words. It sits between the core's fetch stage and the on-chip instruction RAM.

## Interface
- DEPTH_WORDS, 4096: number of 32-bit words; power of two, ≥ 2.
- LATENCY, 2: cycles from request acceptance to ready pulse; legal range 1..15.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- req_addr  in  32  byte address of the requested word; held stable by the initiator while req_valid is high.
- req_valid  in  1  request present; the initiator holds it high until it sees req_ready.
- req_data  out  32  instruction word; meaningful in the req_ready cycle, held until the next response.
- req_ready  out  1  single-cycle pulse: req_data is valid and the request is complete.
- load_addr  in  32  byte address of the program word to write.
- load_data  in  32  program word.
- load_valid  in  1  write request.
- load_ready  out  1  write accepted this cycle; combinational, equal to load_valid when the FSM is in IDLE.

## Operation
- The FSM has two states.
  - IDLE: no request in flight.
  - WAIT: a request has been accepted and the latency counter is running.
- Word index is computed as req_addr[2 +: log2(DEPTH_WORDS)]. The same rule applies to load_addr.
- Behaviour in IDLE:
  - If load_valid is high, the array is written at the load word index and the FSM stays in IDLE. Load takes priority: a simultaneous req_valid is not accepted this cycle and is retried on the next one.
  - Otherwise, if req_valid is high, the request is accepted:
    - the array is read at the index;
    - the word is captured into the internal data register at the end of the acceptance cycle;
    - cnt is set to LATENCY-1 and the FSM moves to WAIT.
- Behaviour in WAIT:
  - req_valid and load_valid are ignored, and load_ready is 0.
  - When cnt is 0, req_ready pulses high for that cycle, req_data drives the captured word, and the FSM returns to IDLE.
  - Otherwise cnt decrements.
- Data is fixed at acceptance. A load to the same word while in WAIT is not possible, because load_ready is 0.
- Back-to-back requests are supported. A request can be accepted in the IDLE cycle immediately after the ready pulse, so sustained throughput is one word every LATENCY+1 cycles.
- Reset:
  - Outputs: req_ready=0, req_data=0, load_ready=0 (by combinational definition while reset is asserted).
  - FSM goes to IDLE and cnt=0.
  - A reset in WAIT aborts the request; no ready pulse follows.
  - Array contents are not cleared by reset.

## Timing
- A request accepted at edge T gives req_ready high during the cycle following edge T+LATENCY-1. With LATENCY=1, ready is high in the cycle immediately after acceptance.
- req_ready is never high for two consecutive cycles.
- req_data changes only at the edge that asserts req_ready.
- A load presented in IDLE is written at that edge. A read accepted on the next cycle returns the new word.
- cnt width is 4 bits.

## Configuration
- Macro INST_MEM_FAULT_EN adds output fault (1 bit, reset 0).
- With the macro defined:
  - a request is faulting if req_addr[1:0] is not 0, or if the addr bits above the index are nonzero;
  - a faulting request is still accepted and timed normally;
  - at ready, req_data=0 and fault=1 for that single cycle;
  - faulting loads are accepted and dropped.
- Without the macro:
  - there is no fault port;
  - the low address bits and the high address bits are ignored (addresses wrap modulo the depth).

## Structure
- Package felis_mem_pkg holds:
  - word_t (logic[31:0]);
  - the state enum {IDLE, WAIT};
  - WORD_BYTES=4.
- Sub-module inst_mem_array implements the storage:
  - one synchronous write port and one read port;
  - registered read data;
  - parameter DEPTH_WORDS;
  - RAM-inferable;
  - no reset.

## Test plan
- Load 0x00000013 at address 0x0, then request address 0x0 with LATENCY=2 → req_ready pulses once, 2 cycles after acceptance, with req_data=0x00000013.
- Assert load_valid and req_valid in the same IDLE cycle to address 0x8 with data 0xDEADBEEF → the load is accepted first, the read is accepted the next cycle, and req_data=0xDEADBEEF.
- Assert reset during WAIT → no req_ready pulse follows, req_data=0, and the next request completes normally.
- Hold req_valid high continuously for addresses 0x0 and 0x4 → exactly one pulse per request, spaced LATENCY+1 cycles apart.
- With INST_MEM_FAULT_EN and DEPTH_WORDS=16, request 0x42 → fault=1 and req_data=0. Request 0x40 → fault=1. Request 0x3C → fault=0.
- Attempt load_valid during WAIT → load_ready=0 and the array is unchanged.

Source files
------------

// File: rtl/felis_mem_pkg.sv
// Shared types for the instruction-memory slice.
//   word_t     : 32-bit instruction / data word
//   state_t    : responder FSM state (IDLE, WAIT)
//   WORD_BYTES : bytes per word; byte addresses drop log2(WORD_BYTES) low bits
package felis_mem_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/inst_mem_array.sv
// Instruction storage: one synchronous write port, one read port with a
// registered output. No reset, so it maps onto block RAM.
//   clk     : clock
//   wr_en   : write strobe
//   wr_idx  : word index to write
//   wr_data : word to write
//   rd_en   : read strobe; rd_data only updates when set
//   rd_idx  : word index to read
//   rd_data : registered read word
module inst_mem_array
   import felis_mem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 4096,
   parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  word_t            wr_data,
   input  logic             rd_en,
   input  logic [IDX_W-1:0] rd_idx,
   output word_t            rd_data
);

   word_t mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_idx] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rd_en) rd_data <= mem[rd_idx];
   end

endmodule

// File: rtl/inst_mem_responder.sv
// Instruction-memory responder: accepts one fetch read at a time, returns the
// word with a one-cycle req_ready pulse LATENCY cycles after acceptance, and
// exposes a boot-loader write port that is only open while idle.
//   clk, reset            : clock, synchronous active-high reset
//   req_addr, req_valid   : fetch request (byte address)
//   req_data, req_ready   : response word and completion pulse
//   load_addr, load_data,
//   load_valid, load_ready: program-load write port
//   fault                 : only with INST_MEM_FAULT_EN; flags a misaligned or
//                           out-of-range request in its ready cycle
// Optional build macro: INST_MEM_FAULT_EN.
//
// state | meaning
// IDLE  | nothing in flight; loads and new requests accepted here
// WAIT  | request accepted, cnt counting down to the ready pulse
module inst_mem_responder
   import felis_mem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 4096,
   parameter int unsigned LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] req_addr,
   input  logic        req_valid,
   output logic [31:0] req_data,
   output logic        req_ready,
   input  logic [31:0] load_addr,
   input  logic [31:0] load_data,
   input  logic        load_valid,
`ifdef INST_MEM_FAULT_EN
   output logic        fault,
`endif
   output logic        load_ready
);

   localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
   localparam int unsigned ADDR_LSB = $clog2(WORD_BYTES);
   localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       accept, resp_fire, load_fire;
   word_t      rd_word, resp_word, resp_q;
   logic       wr_en;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      accept    = 1'b0;
      resp_fire = 1'b0;
      load_fire = 1'b0;
      case (state_q)
         IDLE: begin
            if (load_valid) begin
               load_fire = 1'b1;
            end else if (req_valid) begin
               accept  = 1'b1;
               cnt_d   = CNT_INIT;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               resp_fire = 1'b1;
               state_d   = IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      // Reset wins over everything, including an in-flight ready pulse.
      if (reset) begin
         accept    = 1'b0;
         resp_fire = 1'b0;
         load_fire = 1'b0;
         state_d   = IDLE;
         cnt_d     = 4'd0;
      end
   end

   always_ff @(posedge clk) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
   end

`ifdef INST_MEM_FAULT_EN
   logic req_fault, load_fault, fault_q;

   assign req_fault  = (req_addr[ADDR_LSB-1:0] != '0) ||
                       ((req_addr >> (ADDR_LSB + IDX_W)) != 32'd0);
   assign load_fault = (load_addr[ADDR_LSB-1:0] != '0) ||
                       ((load_addr >> (ADDR_LSB + IDX_W)) != 32'd0);

   // Faulting loads are acknowledged but never reach the array.
   assign wr_en     = load_fire && !load_fault;
   assign resp_word = fault_q ? word_t'(0) : rd_word;
   assign fault     = resp_fire && fault_q;

   always_ff @(posedge clk) begin
      if (reset)       fault_q <= 1'b0;
      else if (accept) fault_q <= req_fault;
   end
`else
   assign wr_en     = load_fire;
   assign resp_word = rd_word;
`endif

   // Address bits outside the word index are don't-care in the default build.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{req_addr, load_addr};

   // rd_word is the capture register loaded at acceptance. It is shown on
   // req_data during the ready cycle and then copied into resp_q, so req_data
   // only moves at the edge that raises req_ready.
   inst_mem_array #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_array (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_idx  (load_addr[ADDR_LSB +: IDX_W]),
      .wr_data (load_data),
      .rd_en   (accept),
      .rd_idx  (req_addr[ADDR_LSB +: IDX_W]),
      .rd_data (rd_word)
   );

   always_ff @(posedge clk) begin
      if (reset)          resp_q <= '0;
      else if (resp_fire) resp_q <= resp_word;
   end

   assign req_ready  = resp_fire;
   assign req_data   = resp_fire ? resp_word : resp_q;
   assign load_ready = load_fire;

endmodule

// File: tb/tb_inst_mem_responder.sv
module tb_inst_mem_responder;
   import felis_mem_pkg::*;

   localparam int unsigned DEPTH   = 16;
   localparam int unsigned LAT     = 2;
   localparam int          TIMEOUT = 20;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] req_addr, load_addr, load_data, req_data;
   logic        req_valid, load_valid, req_ready, load_ready;
`ifdef INST_MEM_FAULT_EN
   logic        fault;
`endif

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   inst_mem_responder #(
      .DEPTH_WORDS (DEPTH),
      .LATENCY     (LAT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req_addr   (req_addr),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .load_addr  (load_addr),
      .load_data  (load_data),
      .load_valid (load_valid),
`ifdef INST_MEM_FAULT_EN
      .fault      (fault),
`endif
      .load_ready (load_ready)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (req_ready !== 1'b1 && n < TIMEOUT) begin
         step();
         n++;
      end
   endtask

   task automatic do_load(input logic [31:0] addr, input logic [31:0] data, input string name);
      load_addr  = addr;
      load_data  = data;
      load_valid = 1'b1;
      #1;
      tests_run++;
      if (load_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL %s: load_ready=%b expected 1", name, load_ready);
      end
      step();
      load_valid = 1'b0;
   endtask

   task automatic do_req(input logic [31:0] addr, input logic [31:0] exp,
                         input logic exp_fault, input string name);
      int n;
      req_addr  = addr;
      req_valid = 1'b1;
      wait_ready(n);
      tests_run++;
      if (n != LAT || req_data !== exp) begin
         tests_failed++;
         $display("FAIL %s: latency=%0d data=%h expected latency=%0d data=%h",
                  name, n, req_data, LAT, exp);
      end
`ifdef INST_MEM_FAULT_EN
      tests_run++;
      if (fault !== exp_fault) begin
         tests_failed++;
         $display("FAIL %s_fault: fault=%b expected %b", name, fault, exp_fault);
      end
`else
      if (exp_fault) $display("note: fault expectation ignored in this build");
`endif
      req_valid = 1'b0;
      step();
      tests_run++;
      if (req_ready !== 1'b0 || req_data !== exp) begin
         tests_failed++;
         $display("FAIL %s_hold: ready=%b data=%h expected ready=0 data=%h",
                  name, req_ready, req_data, exp);
      end
   endtask

   task automatic test_reset();
      reset      = 1'b1;
      req_valid  = 1'b1;
      req_addr   = 32'h0;
      load_valid = 1'b1;
      load_addr  = 32'h0;
      load_data  = 32'hFFFF_FFFF;
      step();
      step();
      tests_run++;
      if (load_ready !== 1'b0 || req_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_ctrl: load_ready=%b req_ready=%b expected 0 0", load_ready, req_ready);
      end
      tests_run++;
      if (req_data !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_data: req_data=%h expected 00000000", req_data);
      end
      req_valid  = 1'b0;
      load_valid = 1'b0;
      reset      = 1'b0;
      step();
   endtask

   task automatic test_load_read();
      do_load(32'h0,  32'h0000_0013, "load_0");
      do_load(32'h4,  32'h0010_0093, "load_4");
      do_load(32'h3C, 32'hCAFE_F00D, "load_3c");
      do_req(32'h0,  32'h0000_0013, 1'b0, "read_0");
      do_req(32'h3C, 32'hCAFE_F00D, 1'b0, "read_3c");
   endtask

   task automatic test_priority();
      int n;
      load_addr  = 32'h8;
      load_data  = 32'hDEAD_BEEF;
      load_valid = 1'b1;
      req_addr   = 32'h8;
      req_valid  = 1'b1;
      #1;
      tests_run++;
      if (load_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL prio_load_ready: load_ready=%b expected 1", load_ready);
      end
      step();
      load_valid = 1'b0;
      wait_ready(n);
      tests_run++;
      if (n + 1 != LAT + 1 || req_data !== 32'hDEAD_BEEF) begin
         tests_failed++;
         $display("FAIL prio_read: cycles=%0d data=%h expected cycles=%0d data=deadbeef",
                  n + 1, req_data, LAT + 1);
      end
      req_valid = 1'b0;
      step();
   endtask

   task automatic test_reset_in_wait();
      int seen;
      req_addr  = 32'h4;
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      reset     = 1'b1;
      step();
      reset = 1'b0;
      tests_run++;
      if (req_ready !== 1'b0 || req_data !== 32'h0) begin
         tests_failed++;
         $display("FAIL abort_reset: ready=%b data=%h expected ready=0 data=00000000",
                  req_ready, req_data);
      end
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         if (req_ready === 1'b1) seen++;
         step();
      end
      tests_run++;
      if (seen != 0 || req_data !== 32'h0) begin
         tests_failed++;
         $display("FAIL abort_no_pulse: pulses=%0d data=%h expected pulses=0 data=00000000",
                  seen, req_data);
      end
      do_req(32'h4, 32'h0010_0093, 1'b0, "after_abort");
   endtask

   task automatic test_back_to_back();
      int n1, n2;
      req_addr  = 32'h0;
      req_valid = 1'b1;
      wait_ready(n1);
      tests_run++;
      if (n1 != LAT || req_data !== 32'h0000_0013) begin
         tests_failed++;
         $display("FAIL b2b_first: latency=%0d data=%h expected latency=%0d data=00000013",
                  n1, req_data, LAT);
      end
      req_addr = 32'h4;
      step();
      wait_ready(n2);
      tests_run++;
      if (n2 + 1 != LAT + 1 || req_data !== 32'h0010_0093) begin
         tests_failed++;
         $display("FAIL b2b_second: spacing=%0d data=%h expected spacing=%0d data=00100093",
                  n2 + 1, req_data, LAT + 1);
      end
      req_valid = 1'b0;
      step();
      tests_run++;
      if (req_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL b2b_single: req_ready=%b expected 0", req_ready);
      end
   endtask

   task automatic test_load_in_wait();
      int n;
      req_addr  = 32'h3C;
      req_valid = 1'b1;
      step();
      load_addr  = 32'h3C;
      load_data  = 32'h5555_5555;
      load_valid = 1'b1;
      #1;
      tests_run++;
      if (load_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL wait_load_ready: load_ready=%b expected 0", load_ready);
      end
      wait_ready(n);
      load_valid = 1'b0;
      req_valid  = 1'b0;
      tests_run++;
      if (n >= TIMEOUT || req_data !== 32'hCAFE_F00D) begin
         tests_failed++;
         $display("FAIL wait_load_data: cycles=%0d data=%h expected data=cafef00d", n, req_data);
      end
      step();
      do_req(32'h3C, 32'hCAFE_F00D, 1'b0, "wait_load_unchanged");
   endtask

   task automatic test_addr_map();
`ifdef INST_MEM_FAULT_EN
      do_req(32'h42, 32'h0, 1'b1, "fault_misaligned");
      do_req(32'h40, 32'h0, 1'b1, "fault_range");
      do_req(32'h3C, 32'hCAFE_F00D, 1'b0, "fault_ok");
`else
      do_req(32'h40, 32'h0000_0013, 1'b0, "wrap_40");
      do_req(32'h42, 32'h0000_0013, 1'b0, "wrap_42");
`endif
   endtask

   initial begin
      test_reset();
      test_load_read();
      test_priority();
      test_reset_in_wait();
      test_back_to_back();
      test_load_in_wait();
      test_addr_map();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
